memory_access_stage: RTL

- Pipeline stage directly downstream of the execute stage. Consumes ALU results (r1/r2), the conditional result (cres), memory-op descriptors (m_a1/m_a2, m_r1_op/m_r2_op) and writeback descriptors (r_a1/r_a2/r_op).
- Performs up to two sequential accesses on a single-port req/ack data bus, then hands results to register writeback.
- Stalls upstream via in_ready while bus transactions are outstanding.

---
 rtl/memory_access_stage_if.sv | 12 +
 rtl/memory_access_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: single-port req/ack data bus between the memory stage and memory
interface memory_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master(output req, we, addr, be, wdata, input rdata, ack);
  modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/memory_access_stage.sv
// memory_access_stage: up to two sequential bus accesses per instruction, then hand-off to writeback
module memory_access_stage (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         cres,
  input  logic [31:0]                  r1,
  input  logic [31:0]                  r2,
  input  logic [31:0]                  m_a1,
  input  logic [31:0]                  m_a2,
  input  logic [3:0]                   m_r1_op,
  input  logic [3:0]                   m_r2_op,
  input  logic [4:0]                   r_a1,
  input  logic [4:0]                   r_a2,
  input  logic [3:0]                   r_op,
  memory_access_stage_if.master        bus,
  output logic                         out_valid,
  output logic [31:0]                  q1,
  output logic [31:0]                  q2,
  output logic [4:0]                   qr_a1,
  output logic [4:0]                   qr_a2,
  output logic [3:0]                   qr_op,
  output logic                         fault
);
  typedef enum logic [1:0] {IDLE, MEM1, MEM2} state_t;
  state_t state, state_n;
  logic [3:0] o1, o2;
  logic [1:0] off1;
  logic [31:0] a2;
  logic act2;
  logic acc, act1_in, act2_in, flt_in, ld_f;
  logic [3:0] f_op;
  logic [31:0] f_a, f_d;
  // access size: 2 word, 1 half, 0 byte, 3 no access
  function automatic logic [1:0] sz(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd2) ? 2'd2 : (op == 4'd5 || op == 4'd6) ? 2'd1 :
           (op == 4'd3 || op == 4'd4) ? 2'd0 : 2'd3;
  endfunction
  function automatic logic ok(input logic [3:0] op, input logic [31:0] a);
    return sz(op) == 2'd2 ? a[1:0] == 2'b00 : sz(op) == 2'd1 ? !a[0] : sz(op) == 2'd0;
  endfunction
  function automatic logic bad(input logic [3:0] op, input logic [31:0] a);
    return sz(op) != 2'd3 && !ok(op, a);
  endfunction
  function automatic logic [3:0] be_of(input logic [3:0] op, input logic [1:0] off);
    return sz(op) == 2'd2 ? 4'hf : sz(op) == 2'd1 ? 4'h3 << off : 4'h1 << off;
  endfunction
  function automatic logic [31:0] wd_of(input logic [3:0] op, input logic [31:0] d);
    return sz(op) == 2'd2 ? d : sz(op) == 2'd1 ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
  function automatic logic [31:0] ld_of(input logic [3:0] op, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {off, 3'b000};
    return sz(op) == 2'd2 ? rd : sz(op) == 2'd1 ? {16'b0, s[15:0]} : {24'b0, s[7:0]};
  endfunction
  assign in_ready = state == IDLE;
  assign acc = in_valid && in_ready;
  assign act1_in = cres && ok(m_r1_op, m_a1);
  assign act2_in = cres && ok(m_r2_op, m_a2);
  assign flt_in = cres && (bad(m_r1_op, m_a1) || bad(m_r2_op, m_a2));
  // next state and the slot whose fields go onto the bus next
  always_comb begin
    state_n = state == IDLE ? (acc ? (act1_in ? MEM1 : act2_in ? MEM2 : IDLE) : IDLE) :
              state == MEM1 ? (bus.ack ? (act2 ? MEM2 : IDLE) : MEM1) :
              (bus.ack ? IDLE : MEM2);
    f_op = state == IDLE ? (act1_in ? m_r1_op : m_r2_op) : o2;
    f_a = state == IDLE ? (act1_in ? m_a1 : m_a2) : a2;
    f_d = state == IDLE ? (act1_in ? r1 : r2) : q2;
    ld_f = (acc && (act1_in || act2_in)) || (state == MEM1 && bus.ack && act2);
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // instruction latch, registered bus outputs and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {bus.req, bus.we, bus.addr, bus.be, bus.wdata} <= '0;
      {out_valid, q1, q2, qr_a1, qr_a2, qr_op, fault} <= '0;
      {o1, o2, off1, a2, act2} <= '0;
    end else begin
      out_valid <= 1'b0;
      if (acc) begin
        q1 <= r1;
        q2 <= r2;
        qr_a1 <= r_a1;
        qr_a2 <= r_a2;
        qr_op <= cres ? r_op : 4'd0;
        fault <= flt_in;
        o1 <= m_r1_op;
        o2 <= m_r2_op;
        off1 <= m_a1[1:0];
        a2 <= m_a2;
        act2 <= act2_in;
        bus.req <= act1_in || act2_in;
        out_valid <= !act1_in && !act2_in;
      end else if (state != IDLE && bus.ack) begin
        if (state == MEM1 && !bus.we) q1 <= ld_of(o1, off1, bus.rdata);
        if (state == MEM2 && !bus.we) q2 <= ld_of(o2, a2[1:0], bus.rdata);
        bus.req <= ld_f;
        out_valid <= !ld_f;
      end
      if (ld_f) begin
        bus.addr <= {f_a[31:2], 2'b00};
        bus.we <= !f_op[0];
        bus.be <= be_of(f_op, f_a[1:0]);
        bus.wdata <= wd_of(f_op, f_d);
      end
    end
  end
endmodule
